// File: rtl/mult3_mult4_latch.sv
// mult3 -> mult4 pipeline register for the integer multiply pipe.
// Supports stall (hold), flush (bubble), x0 write suppression, decode
// forwarding-match flags and a wrapping count of captured writebacks.
module mult3_mult4_latch #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mult3_valid_i,
  input  logic [31:0]      mult3_int_write_data_i,
  input  logic [4:0]       mult3_write_addr_i,
  input  logic             mult3_int_write_enable_i,
  input  logic [31:0]      mult3_instruction_i,
  input  logic [31:0]      mult3_pc_i,
  input  logic [4:0]       fwd_rs1_addr_i,
  input  logic [4:0]       fwd_rs2_addr_i,
  output logic             mult4_valid_o,
  output logic [31:0]      mult4_int_write_data_o,
  output logic [4:0]       mult4_write_addr_o,
  output logic             mult4_int_write_enable_o,
  output logic [31:0]      mult4_instruction_o,
  output logic [31:0]      mult4_pc_o,
  output logic             fwd_rs1_hit_o,
  output logic             fwd_rs2_hit_o,
  output logic [CNT_W-1:0] mult_wb_count_o
);

  logic             valid_q;
  logic [31:0]      data_q;
  logic [4:0]       addr_q;
  logic             we_q;
  logic [31:0]      instr_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_d;

  // Write enable as it would be captured on a load; bubbles and x0 never write.
  always_comb begin
    we_d = mult3_valid_i & mult3_int_write_enable_i & (mult3_write_addr_i != 5'd0);
  end

  // Pipeline state: reset > flush > stall > load.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      addr_q  <= 5'd0;
      we_q    <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      // Counter deliberately untouched by a flush.
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      addr_q  <= 5'd0;
      we_q    <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
    end else if (!stall_i) begin
      valid_q <= mult3_valid_i;
      data_q  <= mult3_int_write_data_i;
      addr_q  <= mult3_write_addr_i;
      we_q    <= we_d;
      instr_q <= mult3_instruction_i;
      pc_q    <= mult3_pc_i;
      if (we_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs straight from registers; hits compare registered dest with decode sources.
  always_comb begin
    mult4_valid_o            = valid_q;
    mult4_int_write_data_o   = data_q;
    mult4_write_addr_o       = addr_q;
    mult4_int_write_enable_o = we_q;
    mult4_instruction_o      = instr_q;
    mult4_pc_o               = pc_q;
    mult_wb_count_o          = cnt_q;
    fwd_rs1_hit_o            = we_q & (addr_q == fwd_rs1_addr_i);
    fwd_rs2_hit_o            = we_q & (addr_q == fwd_rs2_addr_i);
  end

endmodule

// File: tb/tb_mult3_mult4_latch.sv
// Directed self-checking bench for mult3_mult4_latch (counter width 4 so wrap is reachable).
module tb_mult3_mult4_latch;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        stall_i;
  logic        flush_i;
  logic        mult3_valid_i;
  logic [31:0] mult3_int_write_data_i;
  logic [4:0]  mult3_write_addr_i;
  logic        mult3_int_write_enable_i;
  logic [31:0] mult3_instruction_i;
  logic [31:0] mult3_pc_i;
  logic [4:0]  fwd_rs1_addr_i;
  logic [4:0]  fwd_rs2_addr_i;
  logic        mult4_valid_o;
  logic [31:0] mult4_int_write_data_o;
  logic [4:0]  mult4_write_addr_o;
  logic        mult4_int_write_enable_o;
  logic [31:0] mult4_instruction_o;
  logic [31:0] mult4_pc_o;
  logic        fwd_rs1_hit_o;
  logic        fwd_rs2_hit_o;
  logic [3:0]  mult_wb_count_o;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_cnt;

  mult3_mult4_latch #(.CNT_W(4)) dut (
    .clk_i                    (clk_i),
    .rsn_i                    (rsn_i),
    .stall_i                  (stall_i),
    .flush_i                  (flush_i),
    .mult3_valid_i            (mult3_valid_i),
    .mult3_int_write_data_i   (mult3_int_write_data_i),
    .mult3_write_addr_i       (mult3_write_addr_i),
    .mult3_int_write_enable_i (mult3_int_write_enable_i),
    .mult3_instruction_i      (mult3_instruction_i),
    .mult3_pc_i               (mult3_pc_i),
    .fwd_rs1_addr_i           (fwd_rs1_addr_i),
    .fwd_rs2_addr_i           (fwd_rs2_addr_i),
    .mult4_valid_o            (mult4_valid_o),
    .mult4_int_write_data_o   (mult4_int_write_data_o),
    .mult4_write_addr_o       (mult4_write_addr_o),
    .mult4_int_write_enable_o (mult4_int_write_enable_o),
    .mult4_instruction_o      (mult4_instruction_o),
    .mult4_pc_o               (mult4_pc_o),
    .fwd_rs1_hit_o            (fwd_rs1_hit_o),
    .fwd_rs2_hit_o            (fwd_rs2_hit_o),
    .mult_wb_count_o          (mult_wb_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic we, input logic [31:0] ins, input logic [31:0] pc);
    mult3_valid_i            = v;
    mult3_int_write_data_i   = d;
    mult3_write_addr_i       = a;
    mult3_int_write_enable_i = we;
    mult3_instruction_i      = ins;
    mult3_pc_i               = pc;
  endtask

  task automatic test_reset();
    rsn_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    fwd_rs1_addr_i = 5'd31; fwd_rs2_addr_i = 5'd31;
    drive(1'b1, 32'hCAFEF00D, 5'd31, 1'b1, 32'h0BADC0DE, 32'h5555AAAA);
    tick();
    tick();
    total++; if (mult4_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", mult4_valid_o); end
    total++; if (mult4_int_write_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got %h want 0", mult4_int_write_data_o); end
    total++; if (mult4_write_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr got %h want 0", mult4_write_addr_o); end
    total++; if (mult4_int_write_enable_o !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", mult4_int_write_enable_o); end
    total++; if (mult4_instruction_o !== 32'd0) begin bad++; $display("FAIL reset_instr got %h want 0", mult4_instruction_o); end
    total++; if (mult4_pc_o !== 32'd0) begin bad++; $display("FAIL reset_pc got %h want 0", mult4_pc_o); end
    total++; if (mult_wb_count_o !== 4'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", mult_wb_count_o); end
    total++; if (fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit got %b want 0", fwd_rs1_hit_o); end
    exp_cnt = 4'd0;
    // First load after release.
    rsn_i = 1'b0;
    drive(1'b1, 32'h12345678, 5'd5, 1'b1, 32'hDEADBEEF, 32'h100);
    tick();
    exp_cnt = 4'd1;
    total++; if (mult4_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid got %b want 1", mult4_valid_o); end
    total++; if (mult4_int_write_data_o !== 32'h12345678) begin bad++; $display("FAIL first_data got %h want 12345678", mult4_int_write_data_o); end
    total++; if (mult4_write_addr_o !== 5'd5) begin bad++; $display("FAIL first_addr got %0d want 5", mult4_write_addr_o); end
    total++; if (mult4_int_write_enable_o !== 1'b1) begin bad++; $display("FAIL first_we got %b want 1", mult4_int_write_enable_o); end
    total++; if (mult4_instruction_o !== 32'hDEADBEEF) begin bad++; $display("FAIL first_instr got %h want deadbeef", mult4_instruction_o); end
    total++; if (mult4_pc_o !== 32'h100) begin bad++; $display("FAIL first_pc got %h want 100", mult4_pc_o); end
    total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL first_cnt got %0d want %0d", mult_wb_count_o, exp_cnt); end
  endtask

  task automatic test_x0();
    drive(1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 32'h11111111, 32'h104);
    fwd_rs1_addr_i = 5'd0;
    tick();
    total++; if (mult4_int_write_enable_o !== 1'b0) begin bad++; $display("FAIL x0_we got %b want 0", mult4_int_write_enable_o); end
    total++; if (mult4_write_addr_o !== 5'd0) begin bad++; $display("FAIL x0_addr got %0d want 0", mult4_write_addr_o); end
    total++; if (mult4_int_write_data_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL x0_data got %h want ffffffff", mult4_int_write_data_o); end
    total++; if (mult4_valid_o !== 1'b1) begin bad++; $display("FAIL x0_valid got %b want 1", mult4_valid_o); end
    total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL x0_cnt got %0d want %0d", mult_wb_count_o, exp_cnt); end
    total++; if (fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL x0_hit got %b want 0", fwd_rs1_hit_o); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h000000A5, 5'd7, 1'b1, 32'h22222222, 32'h200);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    fwd_rs1_addr_i = 5'd7;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 5'd12 + 5'(i), 1'b1, 32'h33333333, 32'h300);
      tick();
      total++; if (mult4_write_addr_o !== 5'd7) begin bad++; $display("FAIL stall_addr[%0d] got %0d want 7", i, mult4_write_addr_o); end
      total++; if (mult4_int_write_data_o !== 32'hA5) begin bad++; $display("FAIL stall_data[%0d] got %h want a5", i, mult4_int_write_data_o); end
      total++; if (mult4_pc_o !== 32'h200) begin bad++; $display("FAIL stall_pc[%0d] got %h want 200", i, mult4_pc_o); end
      total++; if (mult4_int_write_enable_o !== 1'b1) begin bad++; $display("FAIL stall_we[%0d] got %b want 1", i, mult4_int_write_enable_o); end
      total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL stall_cnt[%0d] got %0d want %0d", i, mult_wb_count_o, exp_cnt); end
      total++; if (fwd_rs1_hit_o !== 1'b1) begin bad++; $display("FAIL stall_hit[%0d] got %b want 1", i, fwd_rs1_hit_o); end
    end
    flush_i = 1'b1;
    tick();
    total++; if (mult4_valid_o !== 1'b0) begin bad++; $display("FAIL sflush_valid got %b want 0", mult4_valid_o); end
    total++; if (mult4_int_write_enable_o !== 1'b0) begin bad++; $display("FAIL sflush_we got %b want 0", mult4_int_write_enable_o); end
    total++; if (mult4_pc_o !== 32'd0) begin bad++; $display("FAIL sflush_pc got %h want 0", mult4_pc_o); end
    total++; if (mult4_int_write_data_o !== 32'd0) begin bad++; $display("FAIL sflush_data got %h want 0", mult4_int_write_data_o); end
    total++; if (mult4_write_addr_o !== 5'd0) begin bad++; $display("FAIL sflush_addr got %0d want 0", mult4_write_addr_o); end
    total++; if (mult4_instruction_o !== 32'd0) begin bad++; $display("FAIL sflush_instr got %h want 0", mult4_instruction_o); end
    total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL sflush_cnt got %0d want %0d", mult_wb_count_o, exp_cnt); end
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_forward();
    drive(1'b1, 32'h99, 5'd9, 1'b1, 32'h44444444, 32'h400);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    fwd_rs1_addr_i = 5'd9;
    fwd_rs2_addr_i = 5'd10;
    #1;
    total++; if (fwd_rs1_hit_o !== 1'b1) begin bad++; $display("FAIL fwd_rs1 got %b want 1", fwd_rs1_hit_o); end
    total++; if (fwd_rs2_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_rs2 got %b want 0", fwd_rs2_hit_o); end
    fwd_rs1_addr_i = 5'd8;
    fwd_rs2_addr_i = 5'd9;
    #1;
    total++; if (fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_rs1b got %b want 0", fwd_rs1_hit_o); end
    total++; if (fwd_rs2_hit_o !== 1'b1) begin bad++; $display("FAIL fwd_rs2b got %b want 1", fwd_rs2_hit_o); end
    fwd_rs1_addr_i = 5'd9;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    total++; if (fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_flush_rs1 got %b want 0", fwd_rs1_hit_o); end
    total++; if (fwd_rs2_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_flush_rs2 got %b want 0", fwd_rs2_hit_o); end
    total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL fwd_flush_cnt got %0d want %0d", mult_wb_count_o, exp_cnt); end
  endtask

  task automatic test_bubble();
    drive(1'b0, 32'h44, 5'd4, 1'b1, 32'h55555555, 32'h500);
    fwd_rs1_addr_i = 5'd4;
    tick();
    total++; if (mult4_valid_o !== 1'b0) begin bad++; $display("FAIL bub_valid got %b want 0", mult4_valid_o); end
    total++; if (mult4_int_write_enable_o !== 1'b0) begin bad++; $display("FAIL bub_we got %b want 0", mult4_int_write_enable_o); end
    total++; if (mult4_write_addr_o !== 5'd4) begin bad++; $display("FAIL bub_addr got %0d want 4", mult4_write_addr_o); end
    total++; if (mult4_int_write_data_o !== 32'h44) begin bad++; $display("FAIL bub_data got %h want 44", mult4_int_write_data_o); end
    total++; if (mult4_pc_o !== 32'h500) begin bad++; $display("FAIL bub_pc got %h want 500", mult4_pc_o); end
    total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL bub_cnt got %0d want %0d", mult_wb_count_o, exp_cnt); end
    total++; if (fwd_rs1_hit_o !== 1'b0) begin bad++; $display("FAIL bub_hit got %b want 0", fwd_rs1_hit_o); end
  endtask

  task automatic test_wrap();
    rsn_i = 1'b1;
    tick();
    rsn_i = 1'b0;
    exp_cnt = 4'd0;
    total++; if (mult_wb_count_o !== 4'd0) begin bad++; $display("FAIL wrap_start got %0d want 0", mult_wb_count_o); end
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 32'(i), 5'd3, 1'b1, 32'h66666666, 32'h600 + 32'(4 * i));
      tick();
      exp_cnt = 4'(i % 16);
      total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, mult_wb_count_o, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h01020304; vals[1] = 32'hA0B0C0D0; vals[2] = 32'h0F0F0F0F; vals[3] = 32'h76543210;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 5'(i + 20), 1'b1, ~vals[i], 32'h700 + 32'(4 * i));
      tick();
      exp_cnt = exp_cnt + 4'd1;
      total++; if (mult4_int_write_data_o !== vals[i]) begin bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, mult4_int_write_data_o, vals[i]); end
      total++; if (mult4_write_addr_o !== 5'(i + 20)) begin bad++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, mult4_write_addr_o, i + 20); end
      total++; if (mult4_instruction_o !== ~vals[i]) begin bad++; $display("FAIL b2b_instr[%0d] got %h want %h", i, mult4_instruction_o, ~vals[i]); end
      total++; if (mult_wb_count_o !== exp_cnt) begin bad++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, mult_wb_count_o, exp_cnt); end
    end
    // Reset mid-stream discards the in-flight entry.
    rsn_i = 1'b1;
    drive(1'b1, 32'h87654321, 5'd6, 1'b1, 32'h77777777, 32'h800);
    tick();
    rsn_i = 1'b0;
    total++; if (mult4_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", mult4_valid_o); end
    total++; if (mult4_int_write_data_o !== 32'd0) begin bad++; $display("FAIL midrst_data got %h want 0", mult4_int_write_data_o); end
    total++; if (mult_wb_count_o !== 4'd0) begin bad++; $display("FAIL midrst_cnt got %0d want 0", mult_wb_count_o); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_stall_flush();
    test_forward();
    test_bubble();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
